stopwatch_timer: RTL and testbench
==================================

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 SHALL have parameter TICK_PER_SEC, default 2: tick pulses per one-second count step, at least 1.
REQ-002 SHALL have parameter ADJ_TICKS, default 1: tick pulses per adjust increment, at least 1.
REQ-003 SHALL have parameter MIN_TENS_MAX, default 5: top minutes-tens digit (5 gives 59, 9 gives 99), range 1..9.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 tick  in  1  single-cycle base-rate enable pulse.
REQ-007 clr  in  1  synchronous clear to 00:00, paused.
REQ-008 pause_tgl  in  1  single-cycle pulse that toggles run/pause.
REQ-009 mode  in  1  0 = count up (stopwatch), 1 = count down (timer).
REQ-010 sel  in  1  adjust field: 0 = minutes, 1 = seconds.
REQ-011 adj  in  1  level; high = adjust selected field.
REQ-012 m10  out  4  minutes tens, BCD.
REQ-013 m1  out  4  minutes units, BCD.
REQ-014 s10  out  3  seconds tens, 0..5.
REQ-015 s1  out  4  seconds units, BCD.
REQ-016 running  out  1  high in RUN.
REQ-017 expired  out  1  high in EXPIRED.
REQ-018 wrap  out  1  one-cycle pulse on an up-count wrap to 00:00.
REQ-019 blink  out  1  display-flash phase; toggles on every tick while in ADJUST, 0 otherwise.

Function
REQ-020 SHALL implement states PAUSE, RUN, ADJUST, EXPIRED, registered, with outputs changing only on a clk edge.
REQ-021 Input priority SHALL be, per cycle: clr > adj > pause_tgl > tick.
REQ-022 clr SHALL, from any state: set the digits to 00:00, clear the prescalers, and enter PAUSE on the next edge.
REQ-023 adj high in PAUSE or RUN SHALL enter ADJUST; adj low in ADJUST SHALL enter PAUSE; adj SHALL be ignored in EXPIRED.
REQ-024 pause_tgl SHALL move PAUSE to RUN and RUN to PAUSE; it SHALL be ignored in ADJUST and EXPIRED.
REQ-025 Seconds prescaler SHALL count ticks only in RUN and step the time when tick is high and prescaler = TICK_PER_SEC-1; it SHALL hold in PAUSE.
REQ-026 Up count SHALL run s1 9->0 carry to s10, s10 5->0 carry to m1, m1 9->0 carry to m10; at MIN_TENS_MAX:9:5:9 it SHALL go to 00:00, assert wrap for one cycle and stay in RUN.
REQ-027 Down count SHALL borrow symmetrically (00 seconds -> 59 with minutes -1); a step that reaches 00:00 SHALL enter EXPIRED in the same cycle.
REQ-028 RUN with mode=1 at 00:00 SHALL enter EXPIRED on the next edge, with no digit change.
REQ-029 EXPIRED SHALL hold the digits at 00:00 until clr.
REQ-030 A mode change SHALL take effect on the next step, with no digit change.
REQ-031 ADJUST SHALL increment the selected field by 1 every ADJ_TICKS ticks, regardless of mode; the first increment SHALL occur on the first tick after entry.
REQ-032 Adjust wrap rules: seconds SHALL go 59 to 00; minutes SHALL go (MIN_TENS_MAX,9) to 00; an adjust wrap SHALL NOT carry into the other field and SHALL NOT pulse wrap.
REQ-033 Leaving ADJUST SHALL clear both prescalers.
REQ-034 Digits SHALL always remain valid BCD within their ranges.

Reset
REQ-035 rst_n low SHALL asynchronously force: state PAUSE, digits 0, prescalers 0, running=0, expired=0, wrap=0, blink=0.
REQ-036 Reset deassertion SHALL be synchronised by the integrating top level; the block SHALL treat the first edge with rst_n high as normal operation.
REQ-037 Reset mid-count or mid-adjust SHALL discard all progress; no state SHALL be retained.

Structure
REQ-038 Package stopwatch_pkg SHALL hold the state enum, the digit-width localparams and the default parameter constants.
REQ-039 Sub-module bcd_mod_counter (two-digit BCD, parametrised tens max, inc/dec enable, carry/borrow out) SHALL be instantiated once for seconds and once for minutes.

Verification
REQ-040 Up count, TICK_PER_SEC=2, pause_tgl, then 120 ticks -> 00:59 reads 01:00 on the 120th tick; running=1.
REQ-041 Wrap, preset by adjust to 59:59, mode=0, RUN, 2 ticks -> 00:00 with wrap high for exactly one cycle.
REQ-042 Countdown, adjust minutes to 01 (sel=0, 1 tick), mode=1, RUN, 120 ticks -> 00:59 at tick 2, 00:00 at tick 120 with expired=1; further ticks change nothing.
REQ-043 Priority, clr, adj and pause_tgl asserted in the same cycle while in RUN -> next cycle 00:00, PAUSE, running=0.
REQ-044 Adjust wrap, sel=1 at 00:58, 3 ticks -> 00:59, 00:00, 00:01; minutes unchanged; blink toggles each tick.
REQ-045 Async reset, rst_n pulsed low between edges at 12:34 in RUN -> outputs 0 immediately, with no clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch/timer block: controller state
// encoding, display digit widths, default parameter values and a small
// helper for sizing prescaler counters.
// No ports (package).
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE   = 2'd0,
    ST_RUN     = 2'd1,
    ST_ADJUST  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int BCD_W = 4;   // one BCD digit 0..9
  localparam int M10_W = 4;   // minutes tens (up to 9)
  localparam int M1_W  = 4;   // minutes units
  localparam int S10_W = 3;   // seconds tens (0..5)
  localparam int S1_W  = 4;   // seconds units

  localparam int DEF_TICK_PER_SEC = 2;
  localparam int DEF_ADJ_TICKS    = 1;
  localparam int DEF_MIN_TENS_MAX = 5;

  // Width of a counter holding 0..n-1; never narrower than one bit so a
  // divide-by-one prescaler still has a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_timer_if.sv
// ---------------------------------------------------------------------------
// stopwatch_timer_if
// Groups the control inputs and display/status outputs of stopwatch_timer.
//   tick, clr, pause_tgl, mode, sel, adj : controls (driven by master)
//   m10, m1, s10, s1                     : BCD display digits
//   running, expired, wrap, blink        : status flags
// Modports: master (controller side), slave (stopwatch_timer side).
// ---------------------------------------------------------------------------
interface stopwatch_timer_if;
  import stopwatch_pkg::*;

  logic              tick;
  logic              clr;
  logic              pause_tgl;
  logic              mode;
  logic              sel;
  logic              adj;
  logic [M10_W-1:0]  m10;
  logic [M1_W-1:0]   m1;
  logic [S10_W-1:0]  s10;
  logic [S1_W-1:0]   s1;
  logic              running;
  logic              expired;
  logic              wrap;
  logic              blink;

  modport master (
    output tick, clr, pause_tgl, mode, sel, adj,
    input  m10, m1, s10, s1, running, expired, wrap, blink
  );

  modport slave (
    input  tick, clr, pause_tgl, mode, sel, adj,
    output m10, m1, s10, s1, running, expired, wrap, blink
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter, units 0..9, tens 0..TENS_MAX. Rolls over in both
// directions (TENS_MAX9 -> 00 on inc, 00 -> TENS_MAX9 on dec).
//   clk, rst_n          : clock, async active-low reset
//   i_clr               : synchronous clear to 00 (wins over inc/dec)
//   i_inc, i_dec        : step up / step down (inc wins if both)
//   o_tens, o_units     : registered digits
//   o_carry, o_borrow   : the current value would roll over on an inc/dec;
//                         kept independent of i_inc/i_dec so a parent can
//                         chain counters without a combinational loop
// ---------------------------------------------------------------------------
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int TENS_MAX = 5,
  parameter int TENS_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [TENS_W-1:0] o_tens,
  output logic [BCD_W-1:0]  o_units,
  output logic              o_carry,
  output logic              o_borrow
);

  localparam logic [TENS_W-1:0] TENS_TOP = TENS_W'(TENS_MAX);

  logic [TENS_W-1:0] r_tens;
  logic [BCD_W-1:0]  r_units;
  logic [TENS_W-1:0] w_tens_nxt;
  logic [BCD_W-1:0]  w_units_nxt;

  // Next-value logic: clear, BCD increment or BCD decrement.
  always_comb begin
    w_tens_nxt  = r_tens;
    w_units_nxt = r_units;
    if (i_clr) begin
      w_tens_nxt  = {TENS_W{1'b0}};
      w_units_nxt = 4'd0;
    end else if (i_inc) begin
      if (r_units == 4'd9) begin
        w_units_nxt = 4'd0;
        if (r_tens == TENS_TOP) begin
          w_tens_nxt = {TENS_W{1'b0}};
        end else begin
          w_tens_nxt = r_tens + TENS_W'(1);
        end
      end else begin
        w_units_nxt = r_units + 4'd1;
      end
    end else if (i_dec) begin
      if (r_units == 4'd0) begin
        w_units_nxt = 4'd9;
        if (r_tens == {TENS_W{1'b0}}) begin
          w_tens_nxt = TENS_TOP;
        end else begin
          w_tens_nxt = r_tens - TENS_W'(1);
        end
      end else begin
        w_units_nxt = r_units - 4'd1;
      end
    end else begin
      w_tens_nxt  = r_tens;
      w_units_nxt = r_units;
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= {TENS_W{1'b0}};
      r_units <= 4'd0;
    end else begin
      r_tens  <= w_tens_nxt;
      r_units <= w_units_nxt;
    end
  end

  assign o_tens   = r_tens;
  assign o_units  = r_units;
  assign o_carry  = (r_tens == TENS_TOP) && (r_units == 4'd9);
  assign o_borrow = (r_tens == {TENS_W{1'b0}}) && (r_units == 4'd0);

endmodule

// File: rtl/stopwatch_timer.sv
// ---------------------------------------------------------------------------
// stopwatch_timer
// MM:SS stopwatch (count up) / countdown timer (count down) with a field
// adjust mode. States PAUSE, RUN, ADJUST, EXPIRED. Per-cycle input
// priority is clr > adj > pause_tgl > tick.
//   clk, rst_n : clock, async active-low reset (deassertion synchronised
//                by the integrating level)
//   bus        : stopwatch_timer_if.slave -- controls in, digits/status out
// Parameters: TICK_PER_SEC (ticks per count step), ADJ_TICKS (ticks per
// adjust increment), MIN_TENS_MAX (top minutes-tens digit).
// ---------------------------------------------------------------------------
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_PER_SEC = DEF_TICK_PER_SEC,
  parameter int ADJ_TICKS    = DEF_ADJ_TICKS,
  parameter int MIN_TENS_MAX = DEF_MIN_TENS_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_timer_if.slave bus
);

  localparam int SEC_PW = cnt_width(TICK_PER_SEC);
  localparam int ADJ_PW = cnt_width(ADJ_TICKS);
  localparam logic [SEC_PW-1:0] SEC_LAST = SEC_PW'(TICK_PER_SEC - 1);
  localparam logic [ADJ_PW-1:0] ADJ_LAST = ADJ_PW'(ADJ_TICKS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SEC_PW-1:0] r_sec_pre;
  logic [SEC_PW-1:0] w_sec_pre_nxt;
  logic [ADJ_PW-1:0] r_adj_pre;
  logic [ADJ_PW-1:0] w_adj_pre_nxt;
  logic              r_wrap;
  logic              w_wrap_nxt;
  logic              r_blink;
  logic              w_blink_nxt;
  logic              r_running;
  logic              r_expired;

  logic              w_cnt_clr;
  logic              w_sec_inc;
  logic              w_sec_dec;
  logic              w_min_inc;
  logic              w_min_dec;
  logic              w_sec_carry;
  logic              w_sec_borrow;
  logic              w_min_carry;
  logic              w_min_borrow;
  logic [S10_W-1:0]  w_s10;
  logic [S1_W-1:0]   w_s1;
  logic [M10_W-1:0]  w_m10;
  logic [M1_W-1:0]   w_m1;
  logic              w_at_zero;
  logic              w_at_one_sec;

  bcd_mod_counter #(
    .TENS_MAX (5),
    .TENS_W   (S10_W)
  ) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_sec_inc),
    .i_dec    (w_sec_dec),
    .o_tens   (w_s10),
    .o_units  (w_s1),
    .o_carry  (w_sec_carry),
    .o_borrow (w_sec_borrow)
  );

  bcd_mod_counter #(
    .TENS_MAX (MIN_TENS_MAX),
    .TENS_W   (M10_W)
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_min_inc),
    .i_dec    (w_min_dec),
    .o_tens   (w_m10),
    .o_units  (w_m1),
    .o_carry  (w_min_carry),
    .o_borrow (w_min_borrow)
  );

  // 00:00 and 00:01 detection; a down step from 00:01 lands on zero.
  assign w_at_zero    = w_min_borrow && w_sec_borrow;
  assign w_at_one_sec = w_min_borrow && (w_s10 == 3'd0) && (w_s1 == 4'd1);

  // Next-state, prescaler and counter-enable logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_sec_pre_nxt = r_sec_pre;
    w_adj_pre_nxt = r_adj_pre;
    w_wrap_nxt    = 1'b0;
    w_blink_nxt   = 1'b0;
    w_cnt_clr     = 1'b0;
    w_sec_inc     = 1'b0;
    w_sec_dec     = 1'b0;
    w_min_inc     = 1'b0;
    w_min_dec     = 1'b0;
    if (bus.clr) begin
      w_cnt_clr     = 1'b1;
      w_sec_pre_nxt = {SEC_PW{1'b0}};
      w_adj_pre_nxt = {ADJ_PW{1'b0}};
      w_state_nxt   = ST_PAUSE;
    end else begin
      case (r_state)
        ST_PAUSE: begin
          if (bus.adj) begin
            // Preloading the adjust prescaler makes the first tick count.
            w_state_nxt   = ST_ADJUST;
            w_adj_pre_nxt = ADJ_LAST;
          end else if (bus.pause_tgl) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_RUN: begin
          if (bus.adj) begin
            w_state_nxt   = ST_ADJUST;
            w_adj_pre_nxt = ADJ_LAST;
          end else if (bus.pause_tgl) begin
            w_state_nxt = ST_PAUSE;
          end else if (bus.mode && w_at_zero) begin
            w_state_nxt = ST_EXPIRED;
          end else if (bus.tick) begin
            if (r_sec_pre == SEC_LAST) begin
              w_sec_pre_nxt = {SEC_PW{1'b0}};
              if (bus.mode) begin
                w_sec_dec = 1'b1;
                w_min_dec = w_sec_borrow;
                if (w_at_one_sec) begin
                  w_state_nxt = ST_EXPIRED;
                end else begin
                  w_state_nxt = ST_RUN;
                end
              end else begin
                w_sec_inc  = 1'b1;
                w_min_inc  = w_sec_carry;
                w_wrap_nxt = w_sec_carry && w_min_carry;
              end
            end else begin
              w_sec_pre_nxt = r_sec_pre + SEC_PW'(1);
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_ADJUST: begin
          if (!bus.adj) begin
            w_state_nxt   = ST_PAUSE;
            w_sec_pre_nxt = {SEC_PW{1'b0}};
            w_adj_pre_nxt = {ADJ_PW{1'b0}};
          end else if (bus.tick) begin
            w_blink_nxt = ~r_blink;
            if (r_adj_pre == ADJ_LAST) begin
              // Carry outputs are deliberately ignored: adjust wraps stay
              // within the selected field.
              w_adj_pre_nxt = {ADJ_PW{1'b0}};
              if (bus.sel) begin
                w_sec_inc = 1'b1;
              end else begin
                w_min_inc = 1'b1;
              end
            end else begin
              w_adj_pre_nxt = r_adj_pre + ADJ_PW'(1);
            end
          end else begin
            w_blink_nxt = r_blink;
          end
        end
        ST_EXPIRED: begin
          w_state_nxt = ST_EXPIRED;
        end
        default: begin
          w_state_nxt   = ST_PAUSE;
          w_cnt_clr     = 1'b1;
          w_sec_pre_nxt = {SEC_PW{1'b0}};
          w_adj_pre_nxt = {ADJ_PW{1'b0}};
        end
      endcase
    end
  end

  // State, prescaler and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_PAUSE;
      r_sec_pre <= {SEC_PW{1'b0}};
      r_adj_pre <= {ADJ_PW{1'b0}};
      r_wrap    <= 1'b0;
      r_blink   <= 1'b0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sec_pre <= w_sec_pre_nxt;
      r_adj_pre <= w_adj_pre_nxt;
      r_wrap    <= w_wrap_nxt;
      r_blink   <= w_blink_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_expired <= (w_state_nxt == ST_EXPIRED);
    end
  end

  assign bus.m10     = w_m10;
  assign bus.m1      = w_m1;
  assign bus.s10     = w_s10;
  assign bus.s1      = w_s1;
  assign bus.running = r_running;
  assign bus.expired = r_expired;
  assign bus.wrap    = r_wrap;
  assign bus.blink   = r_blink;

endmodule

// File: tb/tb_stopwatch_timer.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_timer
// Directed bench for stopwatch_timer (TICK_PER_SEC=2, ADJ_TICKS=1,
// MIN_TENS_MAX=5). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so each check sees the result of
// the edge just taken. Expected values are worked out by hand below.
// ---------------------------------------------------------------------------
module tb_stopwatch_timer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  stopwatch_timer_if bus ();

  stopwatch_timer #(
    .TICK_PER_SEC (2),
    .ADJ_TICKS    (1),
    .MIN_TENS_MAX (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      cyc();
    end
    bus.tick = 1'b0;
  endtask

  task automatic chk_time(input string tag, input logic [3:0] m10, input logic [3:0] m1,
                          input logic [2:0] s10, input logic [3:0] s1);
    logic [14:0] obs;
    logic [14:0] exp_v;
    obs   = {bus.m10, bus.m1, bus.s10, bus.s1};
    exp_v = {m10, m1, s10, s1};
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.clr = 1'b0; bus.pause_tgl = 1'b0;
    bus.mode = 1'b0; bus.sel = 1'b0; bus.adj = 1'b0;

    // Reset state.
    #12;
    chk_time("reset_digits", 4'd0, 4'd0, 3'd0, 4'd0);
    chk_bit("reset_running", bus.running, 1'b0);
    chk_bit("reset_expired", bus.expired, 1'b0);
    chk_bit("reset_wrap", bus.wrap, 1'b0);
    chk_bit("reset_blink", bus.blink, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Up count: 120 ticks = 60 steps, 00:59 after 118 ticks, 01:00 at 120.
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    chk_bit("up_running", bus.running, 1'b1);
    ticks(1);
    chk_time("up_prescale", 4'd0, 4'd0, 3'd0, 4'd0);
    ticks(117);
    chk_time("up_t118", 4'd0, 4'd0, 3'd5, 4'd9);
    ticks(2);
    chk_time("up_t120", 4'd0, 4'd1, 3'd0, 4'd0);
    chk_bit("up_running_end", bus.running, 1'b1);
    chk_bit("up_no_wrap", bus.wrap, 1'b0);

    // Pause holds the time.
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    ticks(3);
    chk_time("pause_hold", 4'd0, 4'd1, 3'd0, 4'd0);
    chk_bit("pause_running", bus.running, 1'b0);

    // Priority: clr + adj + pause_tgl together while running.
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    ticks(3);
    chk_time("prio_pre", 4'd0, 4'd1, 3'd0, 4'd1);
    bus.clr = 1'b1; bus.adj = 1'b1; bus.pause_tgl = 1'b1;
    cyc();
    bus.clr = 1'b0; bus.adj = 1'b0; bus.pause_tgl = 1'b0;
    chk_time("prio_digits", 4'd0, 4'd0, 3'd0, 4'd0);
    chk_bit("prio_running", bus.running, 1'b0);
    chk_bit("prio_blink", bus.blink, 1'b0);
    ticks(2);
    chk_time("prio_paused", 4'd0, 4'd0, 3'd0, 4'd0);

    // Wrap: adjust to 59:59, run up, second step wraps to 00:00.
    bus.adj = 1'b1; bus.sel = 1'b0; cyc();
    ticks(59);
    bus.sel = 1'b1;
    ticks(59);
    chk_time("adj_5959", 4'd5, 4'd9, 3'd5, 4'd9);
    bus.adj = 1'b0; cyc();
    bus.mode = 1'b0;
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    ticks(1);
    chk_time("wrap_pre", 4'd5, 4'd9, 3'd5, 4'd9);
    chk_bit("wrap_pre_flag", bus.wrap, 1'b0);
    ticks(1);
    chk_time("wrap_digits", 4'd0, 4'd0, 3'd0, 4'd0);
    chk_bit("wrap_flag", bus.wrap, 1'b1);
    chk_bit("wrap_running", bus.running, 1'b1);
    cyc();
    chk_bit("wrap_one_cycle", bus.wrap, 1'b0);

    // Countdown from 01:00: 00:59 at tick 2, 00:01 after 119, 00:00 at 120.
    bus.clr = 1'b1; cyc(); bus.clr = 1'b0;
    bus.adj = 1'b1; bus.sel = 1'b0; cyc();
    ticks(1);
    bus.adj = 1'b0; cyc();
    chk_time("dn_preset", 4'd0, 4'd1, 3'd0, 4'd0);
    bus.mode = 1'b1;
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    ticks(2);
    chk_time("dn_t2", 4'd0, 4'd0, 3'd5, 4'd9);
    ticks(117);
    chk_time("dn_t119", 4'd0, 4'd0, 3'd0, 4'd1);
    chk_bit("dn_t119_exp", bus.expired, 1'b0);
    ticks(1);
    chk_time("dn_t120", 4'd0, 4'd0, 3'd0, 4'd0);
    chk_bit("dn_expired", bus.expired, 1'b1);
    chk_bit("dn_not_running", bus.running, 1'b0);
    ticks(4);
    chk_time("exp_hold", 4'd0, 4'd0, 3'd0, 4'd0);
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    chk_bit("exp_ign_pause", bus.expired, 1'b1);
    bus.adj = 1'b1; ticks(2); bus.adj = 1'b0;
    chk_bit("exp_ign_adj", bus.expired, 1'b1);
    chk_time("exp_ign_adj_t", 4'd0, 4'd0, 3'd0, 4'd0);

    // RUN in down mode at 00:00 expires on the next edge.
    bus.clr = 1'b1; cyc(); bus.clr = 1'b0;
    chk_bit("clr_exp", bus.expired, 1'b0);
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    chk_bit("z_running", bus.running, 1'b1);
    cyc();
    chk_bit("z_expired", bus.expired, 1'b1);
    chk_time("z_digits", 4'd0, 4'd0, 3'd0, 4'd0);
    bus.clr = 1'b1; cyc(); bus.clr = 1'b0;

    // Adjust seconds wrap 58 -> 59 -> 00 -> 01, blink toggling per tick.
    bus.mode = 1'b0;
    bus.adj = 1'b1; bus.sel = 1'b1; cyc();
    chk_bit("blink_entry", bus.blink, 1'b0);
    ticks(58);
    chk_time("aw_58", 4'd0, 4'd0, 3'd5, 4'd8);
    chk_bit("blink_58", bus.blink, 1'b0);
    ticks(1);
    chk_time("aw_59", 4'd0, 4'd0, 3'd5, 4'd9);
    chk_bit("blink_59", bus.blink, 1'b1);
    ticks(1);
    chk_time("aw_00", 4'd0, 4'd0, 3'd0, 4'd0);
    chk_bit("blink_00", bus.blink, 1'b0);
    chk_bit("aw_no_wrap", bus.wrap, 1'b0);
    ticks(1);
    chk_time("aw_01", 4'd0, 4'd0, 3'd0, 4'd1);
    chk_bit("blink_01", bus.blink, 1'b1);
    bus.adj = 1'b0; cyc();
    chk_bit("blink_exit", bus.blink, 1'b0);

    // Async reset at 12:34 while running.
    bus.adj = 1'b1; bus.sel = 1'b0; cyc();
    ticks(12);
    bus.sel = 1'b1;
    ticks(33);
    bus.adj = 1'b0; cyc();
    bus.pause_tgl = 1'b1; cyc(); bus.pause_tgl = 1'b0;
    ticks(1);
    chk_time("ar_pre", 4'd1, 4'd2, 3'd3, 4'd4);
    chk_bit("ar_pre_run", bus.running, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_time("ar_digits", 4'd0, 4'd0, 3'd0, 4'd0);
    chk_bit("ar_running", bus.running, 1'b0);
    chk_bit("ar_expired", bus.expired, 1'b0);
    #1;
    rst_n = 1'b1;
    ticks(3);
    chk_time("ar_after", 4'd0, 4'd0, 3'd0, 4'd0);
    chk_bit("ar_after_run", bus.running, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
